config_loader: RTL

CONFIG_LOADER -- requirements
Module: config_loader

---
 rtl/config_loader_if.sv | 28 ++
 rtl/config_loader.sv | 119 +++++++++++
 2 files changed

// File: rtl/config_loader_if.sv
// Host-side word handshake and configuration-chain drive signals for config_loader.
// The host/bench holds the master modport; the loader holds the slave modport.
interface config_loader_if #(
  parameter int WORD_WIDTH   = 8,
  parameter int CHAIN_LENGTH = 524
);
  localparam int COUNT_WIDTH = $clog2(CHAIN_LENGTH + 1);

  logic                   start;
  logic                   word_valid;
  logic [WORD_WIDTH-1:0]  word_data;
  logic                   word_ready;
  logic                   config_enable;
  logic                   config_data;
  logic                   busy;
  logic                   done;
  logic [COUNT_WIDTH-1:0] bit_count;

  modport master (
    output start, word_valid, word_data,
    input  word_ready, config_enable, config_data, busy, done, bit_count
  );

  modport slave (
    input  start, word_valid, word_data,
    output word_ready, config_enable, config_data, busy, done, bit_count
  );
endinterface

// File: rtl/config_loader.sv
// Serialises host words MSB-first into a CHAIN_LENGTH-bit configuration shift chain,
// requesting one word at a time and truncating the final word to the bits still needed.
module config_loader #(
  parameter int CHAIN_LENGTH = 524,
  parameter int WORD_WIDTH   = 8
) (
  input logic            clock,
  input logic            reset,
  config_loader_if.slave bus
);
  localparam int COUNT_WIDTH = $clog2(CHAIN_LENGTH + 1);
  localparam int SHIFT_WIDTH = $clog2(WORD_WIDTH + 1);
  localparam logic [COUNT_WIDTH-1:0] LAST_BIT   = COUNT_WIDTH'(CHAIN_LENGTH - 1);
  localparam logic [SHIFT_WIDTH-1:0] LAST_SHIFT = SHIFT_WIDTH'(WORD_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 state_reg, state_next;
  logic [WORD_WIDTH-1:0]  word_reg, word_next;
  logic [WORD_WIDTH-1:0]  word_shifted;
  logic [COUNT_WIDTH-1:0] bit_count_reg, bit_count_next;
  logic [SHIFT_WIDTH-1:0] shift_count_reg, shift_count_next;

  logic word_ready_next;
  logic config_enable_next;
  logic config_data_next;
  logic busy_next;
  logic done_next;

  // Left shift built bitwise so a single-bit word width needs no special slice.
  genvar gi;
  generate
    for (gi = 0; gi < WORD_WIDTH; gi++) begin : g_shift
      if (gi == 0) begin : g_lsb
        assign word_shifted[gi] = 1'b0;
      end else begin : g_bit
        assign word_shifted[gi] = word_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= IDLE;
      word_reg        <= '0;
      bit_count_reg   <= '0;
      shift_count_reg <= '0;
    end else begin
      state_reg       <= state_next;
      word_reg        <= word_next;
      bit_count_reg   <= bit_count_next;
      shift_count_reg <= shift_count_next;
    end
  end

  always_comb begin
    state_next         = state_reg;
    word_next          = word_reg;
    bit_count_next     = bit_count_reg;
    shift_count_next   = shift_count_reg;
    word_ready_next    = 1'b0;
    config_enable_next = 1'b0;
    config_data_next   = 1'b0;
    busy_next          = 1'b0;
    done_next          = 1'b0;

    case (state_reg)
      IDLE, DONE: begin
        done_next = (state_reg == DONE);
        if (bus.start) begin
          state_next     = LOAD;
          bit_count_next = '0;
        end
      end

      LOAD: begin
        word_ready_next = 1'b1;
        busy_next       = 1'b1;
        if (bus.word_valid) begin
          word_next        = bus.word_data;
          shift_count_next = '0;
          state_next       = SHIFT;
        end
      end

      SHIFT: begin
        busy_next          = 1'b1;
        config_enable_next = 1'b1;
        config_data_next   = word_reg[WORD_WIDTH-1];
        word_next          = word_shifted;
        bit_count_next     = bit_count_reg + COUNT_WIDTH'(1);
        shift_count_next   = shift_count_reg + SHIFT_WIDTH'(1);
        // Chain-full check first: the last word may be cut short mid-way.
        if (bit_count_reg == LAST_BIT) begin
          state_next = DONE;
        end else if (shift_count_reg == LAST_SHIFT) begin
          state_next = LOAD;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.word_ready    = word_ready_next;
  assign bus.config_enable = config_enable_next;
  assign bus.config_data   = config_data_next;
  assign bus.busy          = busy_next;
  assign bus.done          = done_next;
  assign bus.bit_count     = bit_count_reg;

endmodule
